// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
//   Shared types for the fetch-stage branch target buffer.
//   - Control-transfer class encodings (BR_COND/BR_JUMP/BR_CALL/BR_RET).
//   - btb_entry_t: one stored BTB entry {valid, tag, target, br_type}.
//   - Default PC width and tag width.
//   btb_entry_t is sized by these defaults. branch_target_buffer refuses to
//   elaborate with a PC_WIDTH/TAG_BITS that does not match them.
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam int BR_PC_WIDTH = 32;
    localparam int BR_TAG_BITS = 8;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    typedef struct packed {
        logic                   valid;
        logic [BR_TAG_BITS-1:0] tag;
        logic [BR_PC_WIDTH-1:0] target;
        br_type_e               br_type;
    } btb_entry_t;

endpackage

// File: rtl/return_address_stack.sv
// ----------------------------------------------------------------------------
// return_address_stack
//   Circular speculative return-address stack.
//   A push when full overwrites the oldest entry, and count saturates.
//   flush resets only count and pointer. The stored entries are kept.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (count/pointer only)
//     flush         pipeline redirect: empties the stack logically
//     push          push push_addr (flush takes priority)
//     push_addr     return address to push
//     pop           drop the top entry (caller guarantees count > 0)
//     top           current top-of-stack address (combinational)
//     count         number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module return_address_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;      // next slot to write
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] ptr_inc, ptr_dec;

    assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;

    assign top   = stack_q[ptr_dec];
    assign count = count_q;

    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (flush) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push) begin
            // When full, ptr_q points at the oldest entry, so it gets replaced
            stack_d[ptr_q] = push_addr;
            ptr_d          = ptr_inc;
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            ptr_d   = ptr_dec;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// ----------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped, tagged BTB. It is looked up combinationally at fetch and
//   trained from EX/MEM.
//   Configuration macro: BTB_RAS_EN. When it is defined, a return-address
//   stack supplies targets for return hits. When it is undefined, returns use
//   the stored target. The ports are identical in both builds.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (clears valid bits)
//     lookup_valid    fetch PC valid
//     lookup_pc       fetch PC
//     hit             valid entry with matching tag
//     pred_target     predicted target (0 on miss)
//     pred_type       predicted class (0 on miss)
//     update          resolved control transfer from EX/MEM (1-cycle pulse)
//     update_pc       PC of the resolved instruction
//     update_target   resolved target
//     update_type     resolved class
//     update_taken    resolved direction
//     flush           pipeline redirect (affects only the return stack)
// ----------------------------------------------------------------------------
module branch_target_buffer
    import branch_pkg::*;
#(
    parameter int PC_WIDTH   = BR_PC_WIDTH,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = BR_TAG_BITS,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                hit,
    output logic [PC_WIDTH-1:0] pred_target,
    output logic [1:0]          pred_type,
    input  logic                update,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic [PC_WIDTH-1:0] update_target,
    input  logic [1:0]          update_type,
    input  logic                update_taken,
    input  logic                flush
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    // The entry struct is sized by the package widths.
    if (PC_WIDTH != BR_PC_WIDTH || TAG_BITS != BR_TAG_BITS) begin : g_width_check
        $error("branch_target_buffer: PC_WIDTH/TAG_BITS must match branch_pkg");
    end

    btb_entry_t entries_q [ENTRIES];
    btb_entry_t entries_d [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0]   lk_tag, up_tag;
    btb_entry_t            lk_entry;
    logic                  wr_en;
    logic                  lk_hit;
    logic                  ras_nonempty;
    logic [PC_WIDTH-1:0]   ras_top;

    assign lk_idx   = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag   = lookup_pc[TAG_HI:TAG_LO];
    assign up_idx   = update_pc[INDEX_BITS+1:2];
    assign up_tag   = update_pc[TAG_HI:TAG_LO];
    assign lk_entry = entries_q[lk_idx];

    // Not-taken conditional branches neither allocate nor evict
    assign wr_en  = update & (update_taken | (update_type != BR_COND));
    assign lk_hit = lookup_valid & lk_entry.valid & (lk_entry.tag == lk_tag);
    assign hit    = lk_hit;

    always_comb begin
        entries_d = entries_q;
        if (wr_en) begin
            entries_d[up_idx].valid   = 1'b1;
            entries_d[up_idx].tag     = up_tag;
            entries_d[up_idx].target  = update_target;
            entries_d[up_idx].br_type = br_type_e'(update_type);
        end
    end

    // Lookup reads entries_q, so a same-cycle write is not bypassed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

`ifdef BTB_RAS_EN
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [RAS_CNT_W-1:0] ras_count;
    logic                 ras_push, ras_pop;

    assign ras_push     = lk_hit & (lk_entry.br_type == BR_CALL);
    assign ras_pop      = lk_hit & (lk_entry.br_type == BR_RET) & ras_nonempty;
    assign ras_nonempty = (ras_count != '0);

    return_address_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (PC_WIDTH),
        .CNT_W (RAS_CNT_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (ras_push),
        .push_addr (lookup_pc + PC_WIDTH'(4)),
        .pop       (ras_pop),
        .top       (ras_top),
        .count     (ras_count)
    );
`else
    assign ras_nonempty = 1'b0;
    assign ras_top      = '0;
`endif

    always_comb begin
        pred_target = '0;
        pred_type   = BR_COND;
        if (lk_hit) begin
            pred_type = lk_entry.br_type;
            // An empty stack falls back to the stored target
            if (lk_entry.br_type == BR_RET && ras_nonempty) begin
                pred_target = ras_top;
            end else begin
                pred_target = lk_entry.target;
            end
        end
    end

    // These bits do not take part in indexing or tagging
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], lookup_pc[PC_WIDTH-1:TAG_HI+1],
                           update_pc[1:0], update_pc[PC_WIDTH-1:TAG_HI+1],
                           flush, 1'(RAS_DEPTH)};

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        hit;
    logic [31:0] pred_target;
    logic [1:0]  pred_type;
    logic        update;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic [1:0]  update_type;
    logic        update_taken;
    logic        flush;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per index, holding the full PC that wrote it.
    // The return stack is a list of addresses capped at 4 entries.
    bit          m_valid [64];
    logic [31:0] m_pc    [64];
    logic [31:0] m_tgt   [64];
    logic [1:0]  m_ty    [64];
    logic [31:0] ras [$];

    logic        exp_hit;
    logic [31:0] exp_tgt;
    logic [1:0]  exp_ty;

    branch_target_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .hit           (hit),
        .pred_target   (pred_target),
        .pred_type     (pred_type),
        .update        (update),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_type   (update_type),
        .update_taken  (update_taken),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    function automatic void model_lookup(output logic h, output logic [31:0] t,
                                         output logic [1:0] ty);
        int idx;
        idx = int'((lookup_pc >> 2) % 64);
        h  = lookup_valid && m_valid[idx] &&
             (((m_pc[idx] >> 8) & 32'hFF) == ((lookup_pc >> 8) & 32'hFF));
        t  = 32'h0;
        ty = 2'b00;
        if (h) begin
            t  = m_tgt[idx];
            ty = m_ty[idx];
`ifdef BTB_RAS_EN
            if (ty == 2'b11 && ras.size() > 0) t = ras[ras.size()-1];
`endif
        end
    endfunction

    // Advance one clock and apply the same edge to the model
    task automatic tick();
        logic        h;
        logic [31:0] t;
        logic [1:0]  ty;
        int          idx;
        model_lookup(h, t, ty);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            ras.delete();
        end else begin
            if (update && (update_taken || update_type != 2'b00)) begin
                idx = int'((update_pc >> 2) % 64);
                m_valid[idx] = 1'b1;
                m_pc[idx]    = update_pc;
                m_tgt[idx]   = update_target;
                m_ty[idx]    = update_type;
            end
`ifdef BTB_RAS_EN
            if (flush) ras.delete();
            else if (h && ty == 2'b10) begin
                ras.push_back(lookup_pc + 32'd4);
                if (ras.size() > 4) void'(ras.pop_front());
            end else if (h && ty == 2'b11 && ras.size() > 0) void'(ras.pop_back());
`endif
        end
        @(negedge clk);
        update       = 1'b0;
        flush        = 1'b0;
        lookup_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [1:0] ty, input logic taken);
        update        = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_type   = ty;
        update_taken  = taken;
        tick();
    endtask

    task automatic probe(input logic v, input logic [31:0] pc);
        lookup_valid = v;
        lookup_pc    = pc;
        #1;
        model_lookup(exp_hit, exp_tgt, exp_ty);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        probe(1'b1, 32'h100);
        tests++;
        if ({hit, pred_type, pred_target} !== {1'b0, 2'b00, 32'h0}) begin
            fails++;
            $display("FAIL reset_lookup: hit=%0b type=%0d tgt=%h, want 0/0/0", hit, pred_type, pred_target);
        end
    endtask

    task automatic test_basic();
        logic [31:0] pcs  [4] = '{32'h100, 32'h102, 32'h103, 32'h100};
        logic        vs   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        hits [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        train(32'h100, 32'h180, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            probe(vs[i], pcs[i]);
            tests++;
            if ({hit, pred_type, pred_target} !== {hits[i], 2'b00, hits[i] ? 32'h180 : 32'h0}) begin
                fails++;
                $display("FAIL basic_lookup[%0d]: hit=%0b type=%0d tgt=%h, want hit=%0b tgt 180",
                         i, hit, pred_type, pred_target, hits[i]);
            end
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_not_taken();
        train(32'h200, 32'h280, 2'b00, 1'b0);
        probe(1'b1, 32'h200);
        tests++;
        if (hit !== 1'b0) begin
            fails++;
            $display("FAIL not_taken_alloc: hit=%0b, want 0", hit);
        end
        // A not-taken branch at an existing entry must not evict it
        train(32'h100, 32'h999, 2'b00, 1'b0);
        probe(1'b1, 32'h100);
        tests++;
        if ({hit, pred_target} !== {1'b1, 32'h180}) begin
            fails++;
            $display("FAIL not_taken_evict: hit=%0b tgt=%h, want 1/180", hit, pred_target);
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_alias();
        train(32'h4100, 32'h4400, 2'b01, 1'b1);
        probe(1'b1, 32'h100);
        tests++;
        if (hit !== 1'b0) begin
            fails++;
            $display("FAIL alias_old_miss: hit=%0b, want 0", hit);
        end
        probe(1'b1, 32'h4100);
        tests++;
        if ({hit, pred_type, pred_target} !== {1'b1, 2'b01, 32'h4400}) begin
            fails++;
            $display("FAIL alias_new_hit: hit=%0b type=%0d tgt=%h, want 1/1/4400", hit, pred_type, pred_target);
        end
        // Bits above the tag are ignored, so this produces a tolerated false hit
        probe(1'b1, 32'h14100);
        tests++;
        if ({hit, pred_target} !== {1'b1, 32'h4400}) begin
            fails++;
            $display("FAIL alias_false_hit: hit=%0b tgt=%h, want 1/4400", hit, pred_target);
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        train(32'h100, 32'h180, 2'b00, 1'b1);
        update        = 1'b1;
        update_pc     = 32'h100;
        update_target = 32'h1C0;
        update_type   = 2'b01;
        update_taken  = 1'b1;
        probe(1'b1, 32'h100);
        tests++;
        if ({hit, pred_type, pred_target} !== {1'b1, 2'b00, 32'h180}) begin
            fails++;
            $display("FAIL same_cycle_old: hit=%0b type=%0d tgt=%h, want 1/0/180", hit, pred_type, pred_target);
        end
        tick();
        probe(1'b1, 32'h100);
        tests++;
        if ({hit, pred_type, pred_target} !== {1'b1, 2'b01, 32'h1C0}) begin
            fails++;
            $display("FAIL same_cycle_new: hit=%0b type=%0d tgt=%h, want 1/1/1C0", hit, pred_type, pred_target);
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_returns();
        logic [31:0] calls [5] = '{32'h300, 32'h308, 32'h320, 32'h328, 32'h330};
`ifdef BTB_RAS_EN
        logic [31:0] pops  [5] = '{32'h334, 32'h32C, 32'h324, 32'h30C, 32'hABC};
`else
        logic [31:0] pops  [5] = '{32'hABC, 32'hABC, 32'hABC, 32'hABC, 32'hABC};
`endif
        for (int i = 0; i < 5; i++) train(calls[i], 32'h800, 2'b10, 1'b1);
        train(32'h810, 32'hABC, 2'b11, 1'b1);
        probe(1'b1, 32'h300);
        tests++;
        if ({hit, pred_type, pred_target} !== {1'b1, 2'b10, 32'h800}) begin
            fails++;
            $display("FAIL call_hit: hit=%0b type=%0d tgt=%h, want 1/2/800", hit, pred_type, pred_target);
        end
        tick();
        probe(1'b1, 32'h810);
        tests++;
`ifdef BTB_RAS_EN
        if ({hit, pred_type, pred_target} !== {1'b1, 2'b11, 32'h304}) begin
`else
        if ({hit, pred_type, pred_target} !== {1'b1, 2'b11, 32'hABC}) begin
`endif
            fails++;
            $display("FAIL return_target: hit=%0b type=%0d tgt=%h", hit, pred_type, pred_target);
        end
        tick();
        probe(1'b1, 32'h810);
        tests++;
        if (pred_target !== 32'hABC) begin
            fails++;
            $display("FAIL return_empty: tgt=%h, want ABC", pred_target);
        end
        tick();
        // Five calls into a four-deep stack, then five returns
        for (int i = 0; i < 5; i++) begin
            probe(1'b1, calls[i]);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            probe(1'b1, 32'h810);
            tests++;
            if (pred_target !== pops[i]) begin
                fails++;
                $display("FAIL return_overflow[%0d]: tgt=%h, want %h", i, pred_target, pops[i]);
            end
            tick();
        end
        // flush drops pending returns
        probe(1'b1, 32'h300);
        tick();
        flush = 1'b1;
        tick();
        probe(1'b1, 32'h810);
        tests++;
        if (pred_target !== 32'hABC) begin
            fails++;
            $display("FAIL return_after_flush: tgt=%h, want ABC", pred_target);
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                pc = $urandom;
                pc[15:8] = 8'($urandom_range(0, 3));
                update        = 1'b1;
                update_pc     = pc;
                update_target = $urandom;
                update_type   = 2'($urandom_range(0, 3));
                update_taken  = 1'($urandom_range(0, 1));
            end
            flush = ($urandom_range(0, 15) == 0);
            pc = $urandom;
            pc[15:8] = 8'($urandom_range(0, 3));
            probe(($urandom_range(0, 3) != 0), pc);
            tests++;
            if ({hit, pred_type, pred_target} !== {exp_hit, exp_ty, exp_tgt}) begin
                fails++;
                $display("FAIL random[%0d] pc=%h: hit=%0b type=%0d tgt=%h, want hit=%0b type=%0d tgt=%h",
                         n, pc, hit, pred_type, pred_target, exp_hit, exp_ty, exp_tgt);
            end
            tick();
        end
    endtask

    task automatic test_rst_update();
        train(32'h100, 32'h180, 2'b00, 1'b1);
        rst           = 1'b1;
        update        = 1'b1;
        update_pc     = 32'h500;
        update_target = 32'h580;
        update_type   = 2'b01;
        update_taken  = 1'b1;
        tick();
        rst = 1'b0;
        probe(1'b1, 32'h500);
        tests++;
        if ({hit, pred_type, pred_target} !== {1'b0, 2'b00, 32'h0}) begin
            fails++;
            $display("FAIL rst_blocks_update: hit=%0b type=%0d tgt=%h, want 0/0/0", hit, pred_type, pred_target);
        end
        probe(1'b1, 32'h100);
        tests++;
        if (hit !== 1'b0) begin
            fails++;
            $display("FAIL rst_clears_valid: hit=%0b, want 0", hit);
        end
        lookup_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        lookup_valid  = 1'b0;
        lookup_pc     = 32'h0;
        update        = 1'b0;
        update_pc     = 32'h0;
        update_target = 32'h0;
        update_type   = 2'b00;
        update_taken  = 1'b0;
        flush         = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_not_taken();
        test_alias();
        test_same_cycle();
        test_returns();
        test_random();
        test_rst_update();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
